// File: rtl/game_controller_if.sv
// Command/board/status bundle between the minesweeper sequencer and its neighbours
// (bomb generator, cursor logic, VGA renderer).
interface game_controller_if #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned CNT_W = 4
);
    localparam int unsigned Cells  = SIZE * SIZE;
    localparam int unsigned CoordW = $clog2(SIZE);

    logic                     start;
    logic                     reveal;
    logic                     flag;
    logic [CoordW-1:0]        cur_x;
    logic [CoordW-1:0]        cur_y;
    logic                     gen_done;
    logic [Cells-1:0]         bomb_map;
    logic [Cells*CNT_W-1:0]   count_map;
    logic                     gen_start;
    logic [Cells-1:0]         revealed;
    logic [Cells-1:0]         flagged;
    logic [2:0]               state;
    logic                     busy;

    modport master (
        output start, reveal, flag, cur_x, cur_y, gen_done, bomb_map, count_map,
        input  gen_start, revealed, flagged, state, busy
    );

    modport slave (
        input  start, reveal, flag, cur_x, cur_y, gen_done, bomb_map, count_map,
        output gen_start, revealed, flagged, state, busy
    );
endinterface

// File: rtl/game_controller.sv
// Minesweeper game sequencer: board generation handshake, reveal/flag handling,
// scan-based flood fill of zero-count regions and win/loss detection.
module game_controller #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic               clk_i,
    input logic               rst_ni,
    game_controller_if.slave  bus_io
);
    localparam int unsigned Cells  = SIZE * SIZE;
    localparam int unsigned CoordW = $clog2(SIZE);
    localparam int unsigned IdxW   = $clog2(Cells);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StGen   = 3'd1;
    localparam logic [2:0] StPlay  = 3'd2;
    localparam logic [2:0] StFlood = 3'd3;
    localparam logic [2:0] StLost  = 3'd4;
    localparam logic [2:0] StWon   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [Cells-1:0] revealed_q, revealed_d;
    logic [Cells-1:0] flagged_q, flagged_d;
    logic [IdxW-1:0]  scan_q, scan_d;
    logic             change_q, change_d;
    logic             gen_start_q, gen_start_d;

    logic [Cells-1:0] cnt_zero;
    logic [Cells-1:0] zero_open;
    logic [IdxW-1:0]  cmd_idx;
    logic             win;
    logic             nb_zero;
    logic             flood_hit;

    for (genvar c = 0; c < Cells; c++) begin : g_cnt_zero
        assign cnt_zero[c] = (bus_io.count_map[c*CNT_W +: CNT_W] == '0);
    end

    // Revealed zero-count cells are the seeds the flood spreads from.
    assign zero_open = revealed_q & cnt_zero;
    assign cmd_idx   = {bus_io.cur_y, bus_io.cur_x};
    assign win       = &(revealed_q | bus_io.bomb_map);

    always_comb begin
        int nx;
        int ny;
        nx      = 0;
        ny      = 0;
        nb_zero = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = int'(scan_q[CoordW-1:0]) + dx;
                ny = int'(scan_q[IdxW-1:CoordW]) + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < int'(SIZE) &&
                    ny >= 0 && ny < int'(SIZE)) begin
                    if (zero_open[IdxW'(ny * int'(SIZE) + nx)]) nb_zero = 1'b1;
                end
            end
        end
    end

    assign flood_hit = nb_zero && !revealed_q[scan_q] && !flagged_q[scan_q] &&
                       !bus_io.bomb_map[scan_q];

    always_comb begin
        state_d     = state_q;
        revealed_d  = revealed_q;
        flagged_d   = flagged_q;
        scan_d      = scan_q;
        change_d    = change_q;
        gen_start_d = 1'b0;

        unique case (state_q)
            StIdle, StLost, StWon: begin
                if (bus_io.start) begin
                    gen_start_d = 1'b1;
                    revealed_d  = '0;
                    flagged_d   = '0;
                    scan_d      = '0;
                    change_d    = 1'b0;
                    state_d     = StGen;
                end
            end
            StGen: begin
                if (bus_io.gen_done) state_d = StPlay;
            end
            StPlay: begin
                if (bus_io.start) begin
                    gen_start_d = 1'b1;
                    revealed_d  = '0;
                    flagged_d   = '0;
                    scan_d      = '0;
                    change_d    = 1'b0;
                    state_d     = StGen;
                end else begin
                    if (win) state_d = StWon;
                    if (bus_io.reveal) begin
                        if (!flagged_q[cmd_idx] && !revealed_q[cmd_idx]) begin
                            revealed_d[cmd_idx] = 1'b1;
                            if (bus_io.bomb_map[cmd_idx]) begin
                                state_d = StLost;
                            end else if (cnt_zero[cmd_idx]) begin
                                state_d  = StFlood;
                                scan_d   = '0;
                                change_d = 1'b0;
                            end
                        end
                    end else if (bus_io.flag && !revealed_q[cmd_idx]) begin
                        flagged_d[cmd_idx] = ~flagged_q[cmd_idx];
                    end
                end
            end
            StFlood: begin
                if (flood_hit) begin
                    revealed_d[scan_q] = 1'b1;
                    change_d           = 1'b1;
                end
                if (scan_q == IdxW'(Cells - 1)) begin
                    // A reveal on the last cell still forces another pass.
                    scan_d   = '0;
                    change_d = 1'b0;
                    if (!(change_q || flood_hit)) state_d = StPlay;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            revealed_q  <= '0;
            flagged_q   <= '0;
            scan_q      <= '0;
            change_q    <= 1'b0;
            gen_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            revealed_q  <= revealed_d;
            flagged_q   <= flagged_d;
            scan_q      <= scan_d;
            change_q    <= change_d;
            gen_start_q <= gen_start_d;
        end
    end

    assign bus_io.gen_start = gen_start_q;
    assign bus_io.revealed  = revealed_q;
    assign bus_io.flagged   = flagged_q;
    assign bus_io.state     = state_q;
    assign bus_io.busy      = (state_q == StGen) || (state_q == StFlood);
endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: generation handshake, reveal/flag rules,
// flood-fill pass timing, win/loss and asynchronous reset.
module tb_game_controller;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   n_cyc;

    game_controller_if #(.SIZE(8), .CNT_W(4)) bus ();

    game_controller #(.SIZE(8), .CNT_W(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] counts_of(input logic [63:0] b);
        logic [255:0] r;
        int           cnt;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = 0;
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    if (!(dx == 0 && dy == 0) && (i % 8) + dx >= 0 && (i % 8) + dx < 8 &&
                        (i / 8) + dy >= 0 && (i / 8) + dy < 8) begin
                        if (b[(i / 8 + dy) * 8 + (i % 8) + dx]) cnt++;
                    end
                end
            end
            r[i*4 +: 4] = 4'(cnt);
        end
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic s, input logic r, input logic f, input int x, input int y);
        bus.start  = s;
        bus.reveal = r;
        bus.flag   = f;
        bus.cur_x  = 3'(x);
        bus.cur_y  = 3'(y);
        cycle();
        bus.start  = 1'b0;
        bus.reveal = 1'b0;
        bus.flag   = 1'b0;
    endtask

    task automatic gen_handshake();
        bus.gen_done = 1'b1;
        cycle();
        bus.gen_done = 1'b0;
    endtask

    task automatic wait_flood(output int n);
        n = 0;
        while (bus.busy && n < 2000) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.reveal = 1'b0;
        bus.flag = 1'b0;
        bus.cur_x = '0;
        bus.cur_y = '0;
        bus.gen_done = 1'b0;
        bus.bomb_map = 64'h8000_0000_0000_0000;
        bus.count_map = counts_of(64'h8000_0000_0000_0000);

        #12;
        check_eq("rst_state", 64'(bus.state), 64'd0);
        check_eq("rst_revealed", bus.revealed, 64'd0);
        check_eq("rst_flagged", bus.flagged, 64'd0);
        check_eq("rst_gen_start", 64'(bus.gen_start), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Generation handshake
        cmd(1'b1, 1'b0, 1'b0, 0, 0);
        check_eq("gen_start_pulse", 64'(bus.gen_start), 64'd1);
        check_eq("state_gen", 64'(bus.state), 64'd1);
        cycle();
        check_eq("gen_start_drop", 64'(bus.gen_start), 64'd0);
        repeat (9) cycle();
        check_eq("gen_wait_state", 64'(bus.state), 64'd1);
        check_eq("gen_wait_busy", 64'(bus.busy), 64'd1);
        gen_handshake();
        check_eq("state_play", 64'(bus.state), 64'd2);
        check_eq("play_busy", 64'(bus.busy), 64'd0);

        // Flag (1,1), then flood from (0,0) around it
        cmd(1'b0, 1'b0, 1'b1, 1, 1);
        check_eq("flag_set", bus.flagged, 64'h0000_0000_0000_0200);
        cmd(1'b0, 1'b1, 1'b0, 1, 1);
        check_eq("reveal_flagged", bus.revealed, 64'd0);
        cmd(1'b0, 1'b1, 1'b0, 0, 0);
        check_eq("enter_flood", 64'(bus.state), 64'd3);
        wait_flood(n_cyc);
        check_eq("flood_two_pass_cycles", 64'(n_cyc), 64'd128);
        check_eq("flood_flagged_reveal", bus.revealed, 64'h7FFF_FFFF_FFFF_FDFF);
        cycle();
        cycle();
        check_eq("no_win_flagged", 64'(bus.state), 64'd2);
        cmd(1'b0, 1'b0, 1'b1, 0, 0);
        check_eq("flag_on_revealed", bus.flagged, 64'h0000_0000_0000_0200);
        cmd(1'b0, 1'b0, 1'b1, 1, 1);
        check_eq("flag_clear", bus.flagged, 64'd0);
        cmd(1'b0, 1'b1, 1'b0, 1, 1);
        check_eq("enter_flood_2", 64'(bus.state), 64'd3);
        wait_flood(n_cyc);
        check_eq("flood_one_pass_cycles", 64'(n_cyc), 64'd64);
        check_eq("full_reveal", bus.revealed, 64'h7FFF_FFFF_FFFF_FFFF);
        cycle();
        check_eq("state_won", 64'(bus.state), 64'd5);
        cmd(1'b0, 1'b0, 1'b1, 7, 7);
        check_eq("won_flag_frozen", bus.flagged, 64'd0);

        // Restart from WON, then reset in the middle of the second flood pass
        cmd(1'b1, 1'b0, 1'b0, 0, 0);
        check_eq("restart_gen_start", 64'(bus.gen_start), 64'd1);
        check_eq("restart_cleared", bus.revealed, 64'd0);
        gen_handshake();
        cmd(1'b0, 1'b1, 1'b0, 0, 0);
        repeat (80) cycle();
        check_eq("mid_flood_state", 64'(bus.state), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_state", 64'(bus.state), 64'd0);
        check_eq("async_rst_revealed", bus.revealed, 64'd0);
        check_eq("async_rst_busy", 64'(bus.busy), 64'd0);
        #1 rst_n = 1'b1;
        cycle();

        // Bomb at idx 10
        bus.bomb_map = 64'h0000_0000_0000_0400;
        bus.count_map = counts_of(64'h0000_0000_0000_0400);
        cmd(1'b1, 1'b0, 1'b0, 0, 0);
        gen_handshake();
        cmd(1'b0, 1'b1, 1'b0, 1, 0);
        check_eq("reveal_count1", bus.revealed, 64'h0000_0000_0000_0002);
        check_eq("count1_stay_play", 64'(bus.state), 64'd2);
        cmd(1'b0, 1'b0, 1'b1, 1, 0);
        check_eq("flag_revealed_cell", bus.flagged, 64'd0);
        cmd(1'b1, 1'b1, 1'b0, 0, 1);
        check_eq("start_beats_reveal_gs", 64'(bus.gen_start), 64'd1);
        check_eq("start_beats_reveal_rv", bus.revealed, 64'd0);
        check_eq("start_beats_reveal_st", 64'(bus.state), 64'd1);
        gen_handshake();
        cmd(1'b0, 1'b1, 1'b0, 2, 1);
        check_eq("bomb_revealed", bus.revealed, 64'h0000_0000_0000_0400);
        check_eq("state_lost", 64'(bus.state), 64'd4);
        cmd(1'b0, 1'b1, 1'b0, 0, 0);
        check_eq("lost_reveal_frozen", bus.revealed, 64'h0000_0000_0000_0400);
        cmd(1'b0, 1'b0, 1'b1, 3, 3);
        check_eq("lost_flag_frozen", bus.flagged, 64'd0);
        check_eq("lost_stays", 64'(bus.state), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
